// File: rtl/ack_sequencer_8259_if.sv
// Interface bundle for the 8259 acknowledge/EOI sequencer: CPU INTA#, OCW2 writes,
// priority/ISR inputs and the ISR command, INT and vector outputs.
interface ack_sequencer_8259_if;
    logic       interrupt_acknowledge_n;
    logic [7:0] interrupt_request;
    logic [7:0] highest_level_in_service;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       ocw2_write;
    logic [7:0] ocw2_data;
    logic       interrupt_to_cpu;
    logic [7:0] interrupt;
    logic       start_in_service;
    logic [7:0] end_of_interrupt;
    logic [2:0] priority_rotate;
    logic [7:0] vector_out;
    logic       vector_out_enable;

    modport master (
        output interrupt_acknowledge_n, interrupt_request, highest_level_in_service,
               vector_base, auto_eoi, ocw2_write, ocw2_data,
        input  interrupt_to_cpu, interrupt, start_in_service, end_of_interrupt,
               priority_rotate, vector_out, vector_out_enable
    );

    modport slave (
        input  interrupt_acknowledge_n, interrupt_request, highest_level_in_service,
               vector_base, auto_eoi, ocw2_write, ocw2_data,
        output interrupt_to_cpu, interrupt, start_in_service, end_of_interrupt,
               priority_rotate, vector_out, vector_out_enable
    );
endinterface

// File: rtl/ack_sequencer_8259.sv
// 8086-mode INTA# sequencer and OCW2/AEOI end-of-interrupt decoder for the 8259 core.
// Every output is a register updated on the edge that samples its trigger.
module ack_sequencer_8259 (
    input  logic                 clock,
    input  logic                 reset,
    ack_sequencer_8259_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

    state_t     state_reg, state_next;
    logic       inta_prev_reg;
    logic [7:0] acked_level_reg, acked_level_next;
    logic       rotate_in_aeoi_reg, rotate_in_aeoi_next;
    logic       interrupt_to_cpu_reg, interrupt_to_cpu_next;
    logic [7:0] interrupt_reg, interrupt_next;
    logic       start_in_service_reg, start_in_service_next;
    logic [7:0] end_of_interrupt_reg, end_of_interrupt_next;
    logic [2:0] priority_rotate_reg, priority_rotate_next;
    logic [7:0] vector_out_reg, vector_out_next;
    logic       vector_out_enable_reg, vector_out_enable_next;

    logic       inta_fall, inta_rise;
    logic [2:0] ocw2_cmd, ocw2_level;
    logic [7:0] ocw2_eoi, aeoi_eoi;
    logic       ocw2_rotate_valid, aeoi_rotate_valid;
    logic [2:0] ocw2_rotate, aeoi_rotate;
    logic       unused_ocw2_bits;

    // One-hot to index; an empty vector maps to 7, which is the spurious vector.
    function automatic logic [2:0] level_index(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (onehot[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign inta_fall        = ~bus.interrupt_acknowledge_n & inta_prev_reg;
    assign inta_rise        = bus.interrupt_acknowledge_n & ~inta_prev_reg;
    assign ocw2_cmd         = bus.ocw2_data[7:5];
    assign ocw2_level       = bus.ocw2_data[2:0];
    assign unused_ocw2_bits = ^bus.ocw2_data[4:3];

    always_comb begin
        state_next            = state_reg;
        acked_level_next      = acked_level_reg;
        vector_out_next       = vector_out_reg;
        interrupt_next        = 8'h00;
        start_in_service_next = 1'b0;
        aeoi_eoi              = 8'h00;
        aeoi_rotate_valid     = 1'b0;
        aeoi_rotate           = 3'd0;
        case (state_reg)
            IDLE: if (inta_fall) begin
                state_next            = ACK1;
                acked_level_next      = bus.interrupt_request;
                interrupt_next        = bus.interrupt_request;
                start_in_service_next = 1'b1;
            end
            ACK1: if (inta_rise) state_next = GAP;
            GAP: if (inta_fall) begin
                state_next      = ACK2;
                vector_out_next = {bus.vector_base, level_index(acked_level_reg)};
            end
            ACK2: if (inta_rise) begin
                state_next = IDLE;
                if (bus.auto_eoi && acked_level_reg != 8'h00) begin
                    aeoi_eoi          = acked_level_reg;
                    aeoi_rotate_valid = rotate_in_aeoi_reg;
                    aeoi_rotate       = level_index(acked_level_reg);
                end
            end
            default: state_next = IDLE;
        endcase

        ocw2_eoi            = 8'h00;
        ocw2_rotate_valid   = 1'b0;
        ocw2_rotate         = 3'd0;
        rotate_in_aeoi_next = rotate_in_aeoi_reg;
        if (bus.ocw2_write) begin
            case (ocw2_cmd)
                3'b001: ocw2_eoi = bus.highest_level_in_service;
                3'b011: ocw2_eoi = 8'h01 << ocw2_level;
                3'b101: begin
                    ocw2_eoi          = bus.highest_level_in_service;
                    ocw2_rotate_valid = |bus.highest_level_in_service;
                    ocw2_rotate       = level_index(bus.highest_level_in_service);
                end
                3'b111: begin
                    ocw2_eoi          = 8'h01 << ocw2_level;
                    ocw2_rotate_valid = 1'b1;
                    ocw2_rotate       = ocw2_level;
                end
                3'b110: begin
                    ocw2_rotate_valid = 1'b1;
                    ocw2_rotate       = ocw2_level;
                end
                3'b100:  rotate_in_aeoi_next = 1'b1;
                3'b000:  rotate_in_aeoi_next = 1'b0;
                default: ;
            endcase
        end

        // Both EOI sources may fire together; the CPU's explicit rotate overrides AEOI's.
        end_of_interrupt_next  = ocw2_eoi | aeoi_eoi;
        priority_rotate_next   = ocw2_rotate_valid ? ocw2_rotate :
                                 aeoi_rotate_valid ? aeoi_rotate : priority_rotate_reg;
        interrupt_to_cpu_next  = (state_next == IDLE) && (bus.interrupt_request != 8'h00);
        vector_out_enable_next = (state_next == ACK2);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg             <= IDLE;
            inta_prev_reg         <= 1'b1;
            acked_level_reg       <= 8'h00;
            rotate_in_aeoi_reg    <= 1'b0;
            interrupt_to_cpu_reg  <= 1'b0;
            interrupt_reg         <= 8'h00;
            start_in_service_reg  <= 1'b0;
            end_of_interrupt_reg  <= 8'h00;
            priority_rotate_reg   <= 3'b111;
            vector_out_reg        <= 8'h00;
            vector_out_enable_reg <= 1'b0;
        end else begin
            state_reg             <= state_next;
            inta_prev_reg         <= bus.interrupt_acknowledge_n;
            acked_level_reg       <= acked_level_next;
            rotate_in_aeoi_reg    <= rotate_in_aeoi_next;
            interrupt_to_cpu_reg  <= interrupt_to_cpu_next;
            interrupt_reg         <= interrupt_next;
            start_in_service_reg  <= start_in_service_next;
            end_of_interrupt_reg  <= end_of_interrupt_next;
            priority_rotate_reg   <= priority_rotate_next;
            vector_out_reg        <= vector_out_next;
            vector_out_enable_reg <= vector_out_enable_next;
        end
    end

    assign bus.interrupt_to_cpu  = interrupt_to_cpu_reg;
    assign bus.interrupt         = interrupt_reg;
    assign bus.start_in_service  = start_in_service_reg;
    assign bus.end_of_interrupt  = end_of_interrupt_reg;
    assign bus.priority_rotate   = priority_rotate_reg;
    assign bus.vector_out        = vector_out_reg;
    assign bus.vector_out_enable = vector_out_enable_reg;
endmodule

// File: tb/tb_ack_sequencer_8259.sv
// Directed bench for ack_sequencer_8259: INTA# pairs, AEOI, OCW2 decode, spurious ack
// and mid-sequence reset, with hand-computed expected values.
module tb_ack_sequencer_8259;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ack_sequencer_8259_if bus();

    ack_sequencer_8259 dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it, inputs change there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ocw2(input logic [7:0] data);
        bus.ocw2_data  = data;
        bus.ocw2_write = 1'b1;
        tick();
        bus.ocw2_write = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_value({tag, " int"},    32'(bus.interrupt_to_cpu),  32'h0);
        check_value({tag, " irq"},    32'(bus.interrupt),         32'h0);
        check_value({tag, " sis"},    32'(bus.start_in_service),  32'h0);
        check_value({tag, " eoi"},    32'(bus.end_of_interrupt),  32'h0);
        check_value({tag, " rot"},    32'(bus.priority_rotate),   32'h7);
        check_value({tag, " vec"},    32'(bus.vector_out),        32'h0);
        check_value({tag, " vec_en"}, 32'(bus.vector_out_enable), 32'h0);
    endtask

    // Two INTA# pulses, checking strobe, vector and the final EOI/rotate values.
    task automatic ack_pair(input string tag, input logic [7:0] exp_irq, input logic [7:0] exp_vec,
                            input logic [7:0] exp_eoi, input logic [2:0] exp_rot);
        check_value({tag, " int_before"}, 32'(bus.interrupt_to_cpu), 32'(exp_irq != 8'h00));
        bus.interrupt_acknowledge_n = 1'b0;
        tick();
        check_value({tag, " sis"},       32'(bus.start_in_service), 32'h1);
        check_value({tag, " irq"},       32'(bus.interrupt),        32'(exp_irq));
        check_value({tag, " int_ack1"},  32'(bus.interrupt_to_cpu), 32'h0);
        tick();
        check_value({tag, " sis_once"},  32'(bus.start_in_service), 32'h0);
        bus.interrupt_acknowledge_n = 1'b1;
        tick();
        check_value({tag, " en_gap"},    32'(bus.vector_out_enable), 32'h0);
        bus.interrupt_acknowledge_n = 1'b0;
        tick();
        check_value({tag, " vec"},       32'(bus.vector_out),        32'(exp_vec));
        check_value({tag, " en_ack2"},   32'(bus.vector_out_enable), 32'h1);
        tick();
        check_value({tag, " en_hold"},   32'(bus.vector_out_enable), 32'h1);
        check_value({tag, " eoi_ack2"},  32'(bus.end_of_interrupt),  32'h0);
        bus.interrupt_acknowledge_n = 1'b1;
        tick();
        check_value({tag, " en_off"},    32'(bus.vector_out_enable), 32'h0);
        check_value({tag, " eoi_end"},   32'(bus.end_of_interrupt),  32'(exp_eoi));
        check_value({tag, " rot_end"},   32'(bus.priority_rotate),   32'(exp_rot));
        tick();
        check_value({tag, " eoi_clear"}, 32'(bus.end_of_interrupt),  32'h0);
    endtask

    initial begin
        bus.interrupt_acknowledge_n  = 1'b1;
        bus.interrupt_request        = 8'h04;
        bus.highest_level_in_service = 8'h00;
        bus.vector_base              = 5'b01000;
        bus.auto_eoi                 = 1'b0;
        bus.ocw2_write               = 1'b0;
        bus.ocw2_data                = 8'h00;

        tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();

        // Normal acknowledge of IR2, no AEOI.
        ack_pair("ack", 8'h04, 8'h42, 8'h00, 3'd7);

        // Rotate-in-AEOI enabled, then AEOI acknowledge of IR2.
        bus.auto_eoi = 1'b1;
        ocw2(8'h80);
        check_value("ocw80 eoi", 32'(bus.end_of_interrupt), 32'h0);
        ack_pair("aeoi", 8'h04, 8'h42, 8'h04, 3'd2);

        // Non-specific EOI without rotation, from a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.auto_eoi = 1'b0;
        bus.highest_level_in_service = 8'h10;
        ocw2(8'h20);
        check_value("ocw20 eoi", 32'(bus.end_of_interrupt), 32'h10);
        check_value("ocw20 rot", 32'(bus.priority_rotate),  32'h7);
        tick();
        check_value("ocw20 eoi_clear", 32'(bus.end_of_interrupt), 32'h0);

        // Rotate on specific EOI, set priority, rotate on empty non-specific EOI.
        ocw2(8'hE5);
        check_value("ocwE5 eoi", 32'(bus.end_of_interrupt), 32'h20);
        check_value("ocwE5 rot", 32'(bus.priority_rotate),  32'h5);
        ocw2(8'hC3);
        check_value("ocwC3 eoi", 32'(bus.end_of_interrupt), 32'h0);
        check_value("ocwC3 rot", 32'(bus.priority_rotate),  32'h3);
        bus.highest_level_in_service = 8'h00;
        ocw2(8'hA0);
        check_value("ocwA0 eoi", 32'(bus.end_of_interrupt), 32'h0);
        check_value("ocwA0 rot", 32'(bus.priority_rotate),  32'h3);

        // Spurious acknowledge with AEOI on: vector index 7, no EOI.
        bus.auto_eoi          = 1'b1;
        bus.interrupt_request = 8'h00;
        tick();
        ack_pair("spur", 8'h00, 8'h47, 8'h00, 3'd3);

        // Reset during GAP, then a complete pair; request changes after the first edge are ignored.
        bus.interrupt_request = 8'h04;
        tick();
        bus.interrupt_acknowledge_n = 1'b0;
        tick();
        bus.interrupt_acknowledge_n = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check_reset_values("midrst");
        reset = 1'b0;
        bus.vector_base       = 5'b10101;
        bus.interrupt_request = 8'h02;
        tick();
        check_value("post int", 32'(bus.interrupt_to_cpu), 32'h1);
        bus.interrupt_acknowledge_n = 1'b0;
        tick();
        check_value("post irq", 32'(bus.interrupt), 32'h02);
        bus.interrupt_request = 8'h40;
        tick();
        bus.interrupt_acknowledge_n = 1'b1;
        tick();
        bus.interrupt_acknowledge_n = 1'b0;
        tick();
        check_value("post vec",    32'(bus.vector_out),        32'hA9);
        check_value("post vec_en", 32'(bus.vector_out_enable), 32'h1);
        bus.interrupt_acknowledge_n = 1'b1;
        tick();
        check_value("post eoi", 32'(bus.end_of_interrupt), 32'h02);
        check_value("post rot", 32'(bus.priority_rotate),  32'h7);
        check_value("post int_back", 32'(bus.interrupt_to_cpu), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
